// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver types: prefix bytes, frame bit positions, event record.
// Imported by the scan receiver and its event FIFO.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
  localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;

  localparam int START = 0;
  localparam int PAR   = 9;
  localparam int STOP  = 10;

  typedef struct packed {
    logic       brk;
    logic       ext;
    logic [7:0] code;
  } ps2_event_t;

endpackage

// File: rtl/ps2_event_fifo.sv
// First-word fall-through FIFO of ps2_event_t.
// Ports: push/din, pop, dout (head, zero when empty), full, empty, count.
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  ps2_event_t               din,
  input  logic                     pop,
  output ps2_event_t               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  ps2_event_t    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a push when the head leaves this cycle.
  assign do_push = push & (~full | do_pop);
  assign count   = cnt;
  assign dout    = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: pin sync, 11-bit frame check, E0/F0 folding,
// idle timeout, buffered key events (valid/ready), sticky overflow, error pulses.
module ps2_scan_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [7:0]                    ev_code,
  output logic                          ev_break,
  output logic                          ev_ext,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          ovf_clr,
  output logic                          err_parity,
  output logic                          err_frame
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   clk_s;
  logic                   dat_s;
  logic                   clk_prev;
  logic                   fall;

  logic [3:0]             bit_cnt;
  logic [10:0]            shreg;
  logic                   frame_done;
  logic                   ext_f;
  logic                   brk_f;
  logic [TW-1:0]          tmo_cnt;
  logic                   tmo_hit;

  logic                   start_ok;
  logic                   stop_ok;
  logic                   par_ok;
  logic                   good;
  logic [7:0]             rx_byte;
  logic                   is_ext;
  logic                   is_brk;

  logic                   push;
  ps2_event_t             push_ev;
  ps2_event_t             head;
  logic                   full;
  logic                   empty;
  logic                   pop;

  // Pins idle high; resetting the chain high avoids a false fall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev <= clk_s;
    end
  end

  assign clk_s = clk_sync[SYNC_STAGES-1];
  assign dat_s = dat_sync[SYNC_STAGES-1];
  assign fall  = clk_prev & ~clk_s;

  // Bits arrive LSB first, so after 11 shifts shreg[i] is frame bit i.
  assign start_ok = ~shreg[START];
  assign stop_ok  = shreg[STOP];
  assign par_ok   = ^shreg[PAR:1];
  assign rx_byte  = shreg[8:1];
  assign good     = frame_done & start_ok & stop_ok & par_ok;
  assign is_ext   = (rx_byte == PS2_EXT_PREFIX);
  assign is_brk   = (rx_byte == PS2_BRK_PREFIX);

  assign tmo_hit = (bit_cnt != 4'd0) & ~fall &
                   (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt    <= '0;
      shreg      <= '0;
      frame_done <= 1'b0;
      tmo_cnt    <= '0;
      ext_f      <= 1'b0;
      brk_f      <= 1'b0;
      err_frame  <= 1'b0;
      err_parity <= 1'b0;
    end else begin
      frame_done <= fall & (bit_cnt == 4'(STOP));
      if (fall) begin
        shreg   <= {dat_s, shreg[10:1]};
        bit_cnt <= (bit_cnt == 4'(STOP)) ? 4'd0 : bit_cnt + 4'd1;
        tmo_cnt <= '0;
      end else if (tmo_hit) begin
        bit_cnt <= '0;
        tmo_cnt <= '0;
      end else if (bit_cnt != 4'd0) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end else begin
        tmo_cnt <= '0;
      end

      if (tmo_hit || (frame_done && !good)) begin
        ext_f <= 1'b0;
        brk_f <= 1'b0;
      end else if (good) begin
        unique case (1'b1)
          is_ext:  ext_f <= 1'b1;
          is_brk:  brk_f <= 1'b1;
          default: begin
            ext_f <= 1'b0;
            brk_f <= 1'b0;
          end
        endcase
      end

      err_frame  <= tmo_hit | (frame_done & ~(start_ok & stop_ok));
      err_parity <= frame_done & start_ok & stop_ok & ~par_ok;
    end
  end

  assign push         = good & ~is_ext & ~is_brk;
  assign push_ev.brk  = brk_f;
  assign push_ev.ext  = ext_f;
  assign push_ev.code = rx_byte;
  assign pop          = ev_valid & ev_ready;

  ps2_event_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_ev),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  assign ev_valid = ~empty;
  assign ev_code  = head.code;
  assign ev_break = head.brk;
  assign ev_ext   = head.ext;

  // Set beats clear when both land in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (push && full && !pop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Scoreboard bench for ps2_scan_rx: directed PS/2 frames, queued expected
// events, monitor pops and compares on each accepted event.
module tb_ps2_scan_rx;

  localparam int H = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       ev_valid;
  logic       ev_ready = 1'b0;
  logic [7:0] ev_code;
  logic       ev_break;
  logic       ev_ext;
  logic [3:0] fifo_count;
  logic       overflow;
  logic       ovf_clr = 1'b0;
  logic       err_parity;
  logic       err_frame;

  int checks = 0;
  int errors = 0;
  int n_par  = 0;
  int n_frm  = 0;
  int cyc    = 0;
  logic [9:0] exp_q[$];

  ps2_scan_rx #(
    .FIFO_DEPTH     (8),
    .TIMEOUT_CYCLES (200),
    .SYNC_STAGES    (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_code    (ev_code),
    .ev_break   (ev_break),
    .ev_ext     (ev_ext),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr),
    .err_parity (err_parity),
    .err_frame  (err_frame)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      if (err_parity) n_par++;
      if (err_frame)  n_frm++;
      if (ev_valid && ev_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event got %h required none",
                   {ev_break, ev_ext, ev_code});
        end else begin
          logic [9:0] e;
          e = exp_q.pop_front();
          if ({ev_break, ev_ext, ev_code} !== e) begin
            errors++;
            $display("FAIL event got %h required %h",
                     {ev_break, ev_ext, ev_code}, e);
          end
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input bit bad_par, input int nbits);
    logic [10:0] fr;
    fr[0]   = 1'b0;
    fr[8:1] = b;
    fr[9]   = ~(^b) ^ bad_par;
    fr[10]  = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      ps2_data = fr[i];
      tick(H);
      ps2_clk = 1'b0;
      tick(H);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    tick(20);
  endtask

  task automatic good(input logic [7:0] b);
    send(b, 1'b0, 11);
  endtask

  initial begin
    int t0;
    bit seen;
    tick(5);
    check("reset_valid", ev_valid, 0);
    check("reset_count", fifo_count, 0);
    check("reset_ovf", overflow, 0);
    check("reset_code", ev_code, 0);
    rst = 1'b1;
    ev_ready = 1'b1;
    tick(5);

    exp_q.push_back({2'b00, 8'h1C});
    good(8'h1C);
    check("t1_count", fifo_count, 0);
    check("t1_no_err", n_par + n_frm, 0);

    exp_q.push_back({2'b10, 8'h1C});
    good(8'hF0);
    check("t2_no_push_f0", fifo_count, 0);
    good(8'h1C);

    exp_q.push_back({2'b11, 8'h75});
    good(8'hE0);
    good(8'hF0);
    good(8'h75);
    exp_q.push_back({2'b00, 8'h75});
    good(8'h75);

    send(8'h1C, 1'b1, 11);
    check("t4_par_err", n_par, 1);
    check("t4_frm_err", n_frm, 0);
    check("t4_count", fifo_count, 0);
    exp_q.push_back({2'b00, 8'h32});
    good(8'h32);

    ev_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) exp_q.push_back({2'b00, 8'(i)});
      good(8'(i));
    end
    check("t5_count", fifo_count, 8);
    check("t5_ovf", overflow, 1);
    check("t5_head", ev_code, 1);
    ev_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (fifo_count == 0) begin
        seen = 1;
        break;
      end
    end
    check("t5_drained", seen, 1);
    check("t5_ovf_sticky", overflow, 1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    tick(1);
    check("t5_ovf_clr", overflow, 0);

    send(8'h5A, 1'b0, 4);
    t0 = cyc - 20 - H;
    seen = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (err_frame) begin
        seen = 1;
        break;
      end
    end
    check("t6_tmo_seen", seen, 1);
    check("t6_tmo_late", int'((cyc - t0) >= 198 && (cyc - t0) <= 210), 1);
    tick(2);
    check("t6_frm_err", n_frm, 1);
    check("t6_bitcnt", dut.bit_cnt, 0);
    exp_q.push_back({2'b00, 8'h5A});
    good(8'h5A);

    ev_ready = 1'b0;
    good(8'h33);
    check("t6_held_count", fifo_count, 1);
    check("t6_held_code", ev_code, 8'h33);
    send(8'hE0, 1'b0, 3);
    ps2_data = 1'b0;
    send(8'h11, 1'b0, 2);
    rst = 1'b0;
    #1;
    check("rst_valid", ev_valid, 0);
    check("rst_count", fifo_count, 0);
    check("rst_code", ev_code, 0);
    check("rst_errs", int'(err_frame | err_parity), 0);
    tick(3);
    rst = 1'b1;
    ev_ready = 1'b1;
    tick(3);
    exp_q.push_back({2'b00, 8'h1C});
    good(8'h1C);

    tick(20);
    check("queue_empty", exp_q.size(), 0);
    check("final_par_errs", n_par, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    repeat (100000) @(posedge clk);
    $display("FAIL watchdog got timeout required finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ps2_scan_rx.md
Name: ps2_scan_rx

Overview:
Parametrised PS/2 keyboard receiver that succeeds the plain byte receiver. It synchronises the PS/2 pins and checks the 11-bit frame (start, parity, stop). It folds E0/F0 prefixes into single key events and buffers the events in a configurable FIFO behind a valid/ready interface. It sits between the board PS/2 pins and the keyboard consumer logic, and adds error reporting, an idle timeout and a clearable sticky overflow flag.

Parameters:
FIFO_DEPTH, 8, event FIFO entries; power of two, >= 2
TIMEOUT_CYCLES, 50000, clk cycles with no ps2_clk fall mid-frame before the frame is aborted
SYNC_STAGES, 2, synchroniser flops on ps2_clk and ps2_data; >= 2

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
ps2_clk  in  1  raw PS/2 clock pin
ps2_data  in  1  raw PS/2 data pin
ev_valid  out  1  FIFO head holds an event
ev_ready  in  1  consumer accepts head when ev_valid=1
ev_code  out  8  scan code of the head event
ev_break  out  1  head event is a key release (F0 prefix seen)
ev_ext  out  1  head event is extended (E0 prefix seen)
fifo_count  out  $clog2(FIFO_DEPTH)+1  events currently buffered
overflow  out  1  sticky: an event was dropped because the FIFO was full
ovf_clr  in  1  clears overflow
err_parity  out  1  one-cycle pulse on parity failure
err_frame  out  1  one-cycle pulse on bad start/stop bit or timeout

Behaviour:
- Reset (rst=0, async) clears everything: ev_valid=0, ev_code=0, ev_break=0, ev_ext=0, fifo_count=0, overflow=0, err_*=0. Bit counter, prefix flags, timeout counter and FIFO pointers are all cleared. Reset mid-frame discards the partial frame.
- Sync: both pins pass through SYNC_STAGES flops. A registered previous ps2_clk value forms a one-cycle "fall" pulse on the synchronised 1->0 transition.
- Frame: on each fall, shift in the synchronised data and increment bit_cnt (0..10).
  - Bit 0 is start and must be 0.
  - Bits 1-8 are data, LSB first.
  - Bit 9 is parity; odd parity over data+parity is required.
  - Bit 10 is stop and must be 1.
  - After bit 10, bit_cnt returns to 0.
- Frame check (cycle after the stop-bit fall):
  - Bad start or stop: err_frame pulses.
  - Otherwise bad parity: err_parity pulses.
  - On any error the byte is discarded and both prefix flags are cleared.
- Decode of a good byte:
  - 8'hE0: set ext_f, no push.
  - 8'hF0: set brk_f, no push.
  - Any other byte (E1 included): push {brk_f, ext_f, byte}, then clear both flags.
- Timeout: when bit_cnt != 0, a counter increments each clk and resets on every fall. When it reaches TIMEOUT_CYCLES:
  - bit_cnt := 0, prefix flags are cleared, err_frame pulses for one cycle.
  - When bit_cnt = 0 the counter is held at 0.
- Latency: the push happens in the frame-check cycle. When the FIFO was empty, ev_valid=1 and the ev_* outputs are valid on the next cycle (first-word fall-through).
- FIFO behaviour:
  - Pop occurs when ev_valid && ev_ready.
  - Push while full without a pop: the new event is dropped, overflow:=1, stored contents are unchanged.
  - Push and pop in the same cycle while full: both occur, no overflow.
  - Push and pop in the same cycle while non-empty: fifo_count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - fifo_count ranges 0..FIFO_DEPTH inclusive.
- Overflow flag: ovf_clr=1 clears overflow. If a new overflow occurs in the same cycle as ovf_clr, set wins.
- ev_* outputs hold stable while ev_valid=1 and ev_ready=0.
- Pin clock rate is 10-16.7 kHz. Back-to-back frames need no gap beyond the PS/2 protocol minimum.

Decomposition:
- Shared package ps2_pkg holds:
  - PS2_EXT_PREFIX=8'hE0 and PS2_BRK_PREFIX=8'hF0.
  - Frame bit indices START=0, PAR=9, STOP=10.
  - Packed event type ps2_event_t {break, ext, code[7:0]}, 10 bits.
- One sub-module, ps2_event_fifo: a parametrised FWFT FIFO of ps2_event_t with push/pop/full/empty/count.
- Sync, frame, timeout and decode logic stay in ps2_scan_rx.

Test Plan:
1. Send a good frame for 8'h1C (key A press), ev_ready=1 -> one event: ev_code=1C, ev_break=0, ev_ext=0; ev_valid high exactly 1 cycle; no err pulses.
2. Send F0 then 1C -> exactly one event: code=1C, break=1, ext=0; nothing pushed for the F0 byte.
3. Send E0, F0, 75 -> one event: code=75, break=1, ext=1. Then send 75 alone -> code=75, break=0, ext=0 (flags cleared).
4. Send 1C with the parity bit inverted -> err_parity one-cycle pulse, fifo_count stays 0. A following good 32 frame yields code=32.
5. Hold ev_ready=0 and send 9 distinct codes 01..09 (FIFO_DEPTH=8):
   - Result: fifo_count=8, overflow=1.
   - Draining yields 01..08 in order; 09 is absent.
   - Pulsing ovf_clr then gives overflow=0.
6. Timeout and reset mid-frame, with TIMEOUT_CYCLES=200:
   - Drive 4 bits then idle -> err_frame pulse 200 cycles after the last fall; bit_cnt=0. Next full frame 5A decodes as code=5A.
   - Assert rst mid-frame -> all outputs return to 0 immediately.
